// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch controller.
// Fetch FSM states, fetch packet bundle and the NOP encoding.
package if_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_pkt_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response channel.
// master = fetch controller, slave = instruction memory.
interface if_fetch_ctrl_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry fetch packet buffer with load/unload/clear.
// Serves as both the decode output slot and the skid entry.
module if_skid_buf
    import if_pkg::*;
#(
    parameter logic [31:0] EMPTY_INST = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       load,
    input  logic       unload,
    input  logic       clear,
    input  fetch_pkt_t din,
    output fetch_pkt_t dout,
    output logic       full
);

    // clear beats load beats unload; emptying keeps the pc field
    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            dout <= {EMPTY_INST, 32'h0};
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (unload) begin
            dout.inst <= EMPTY_INST;
            full      <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one imem
// request at a time and feeds {inst, pc, valid} to decode.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    if_fetch_ctrl_if.master         imem,
    output logic [31:0]             inst_out,
    output logic [31:0]             pc_out,
    output logic                    inst_valid
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;

    fetch_pkt_t   rsp_pkt;
    fetch_pkt_t   slot_d;
    fetch_pkt_t   slot_q;
    fetch_pkt_t   skid_q;
    logic         slot_full;
    logic         skid_full;
    logic         slot_load;
    logic         skid_load;
    logic         skid_unload;
    logic         consume;
    logic         hs;
    logic         rsp_valid;

    assign imem.imem_req_valid = (state == REQ);
    assign imem.imem_req_addr  = pc;

    assign hs        = imem.imem_req_valid & imem.imem_req_ready;
    assign rsp_valid = imem.imem_rsp_valid;
    assign consume   = slot_full & ~stall;
    assign rsp_pkt   = {imem.imem_rsp_data, req_pc};

    // steer a response or the skid entry into the output slot
    always_comb begin
        slot_load   = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        slot_d      = rsp_pkt;
        if (!redirect) begin
            unique case (1'b1)
                (state == WAIT) && rsp_valid: begin
                    if (!slot_full || consume) slot_load = 1'b1;
                    else                       skid_load = 1'b1;
                end
                (state == HOLD) && skid_full && consume: begin
                    slot_load   = 1'b1;
                    skid_unload = 1'b1;
                    slot_d      = skid_q;
                end
                default: ;
            endcase
        end
    end

    // fetch FSM and PC; redirect lands in DRAIN while a request is in flight
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else if (redirect) begin
            pc <= redirect_pc;
            if (((state == REQ) && hs) ||
                (((state == WAIT) || (state == DRAIN)) && !rsp_valid))
                state <= DRAIN;
            else
                state <= REQ;
        end else begin
            unique case (state)
                REQ: if (hs) begin
                    req_pc <= pc;
                    pc     <= pc_next(pc);
                    state  <= WAIT;
                end
                WAIT: if (rsp_valid) begin
                    state <= slot_load ? REQ : HOLD;
                end
                HOLD: if (consume) begin
                    state <= REQ;
                end
                DRAIN: if (rsp_valid) begin
                    state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

    if_skid_buf #(
        .EMPTY_INST (NOP_INST)
    ) u_slot (
        .clk    (clk),
        .nrst   (nrst),
        .load   (slot_load),
        .unload (consume),
        .clear  (redirect),
        .din    (slot_d),
        .dout   (slot_q),
        .full   (slot_full)
    );

    if_skid_buf #(
        .EMPTY_INST (NOP_INST)
    ) u_skid (
        .clk    (clk),
        .nrst   (nrst),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (redirect),
        .din    (rsp_pkt),
        .dout   (skid_q),
        .full   (skid_full)
    );

    assign inst_out   = slot_q.inst;
    assign pc_out     = slot_q.pc;
    assign inst_valid = slot_full;

    // a response is only legal while a request is outstanding
    a_rsp_in_flight: assert property (
        @(posedge clk) disable iff (!nrst)
        rsp_valid |-> ((state == WAIT) || (state == DRAIN))
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycle table plus random
// stimulus checked against an in-order instruction stream model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;

    logic        ready = 1'b0;
    logic        bad = 1'b0;
    logic        rand_lat = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // instruction memory: one request in flight, fixed or random latency
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    assign bus.imem_req_ready = ready;
    assign bus.imem_rsp_valid = pend && (cnt == 0);
    assign bus.imem_rsp_data  = bad ? 32'hDEAD_BEEF : memf(paddr);

    always @(posedge clk) begin
        if (!nrst) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else if (bus.imem_req_valid && ready) begin
            chk("one_outstanding", {31'b0, pend}, 32'd0);
            pend  <= 1'b1;
            paddr <= bus.imem_req_addr;
            cnt   <= rand_lat ? int'($urandom_range(3, 0)) : 1;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end

    typedef struct {
        string       tag;
        logic        n;
        logic        s;
        logic        r;
        logic [31:0] rp;
        logic        rdy;
        logic        b;
        logic        rv;
        logic [31:0] a;
        logic        iv;
        logic [31:0] p;
        logic [31:0] ins;
    } vec_t;

    vec_t v[$];

    function automatic void row(string t, logic n, logic s, logic r,
                                logic [31:0] rp, logic rdy, logic b,
                                logic rv, logic [31:0] a, logic iv,
                                logic [31:0] p, logic [31:0] ins);
        vec_t x;
        x.tag = t; x.n = n; x.s = s; x.r = r; x.rp = rp;
        x.rdy = rdy; x.b = b; x.rv = rv; x.a = a; x.iv = iv;
        x.p = p; x.ins = ins;
        v.push_back(x);
    endfunction

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] r;
        int          gap;
        int          consumes;

        // throughput: 0x0, 0x4, 0x8 one every 3 cycles
        row("thru_rst", 0,0,0,0,1,0, 1,0,0,0,NOPI);
        row("thru_rst", 0,0,0,0,1,0, 1,0,0,0,NOPI);
        row("thru_e0",  1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("thru_e1",  1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("thru_e2",  1,0,0,0,1,0, 1,4,1,0,memf(0));
        row("thru_e3",  1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("thru_e4",  1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("thru_e5",  1,0,0,0,1,0, 1,8,1,4,memf(4));
        row("thru_e6",  1,0,0,0,1,0, 0,0,0,4,NOPI);
        row("thru_e7",  1,0,0,0,1,0, 0,0,0,4,NOPI);
        row("thru_e8",  1,0,0,0,1,0, 1,12,1,8,memf(8));
        // stall 10 cycles: slot holds 0x0, skid 0x4, no request
        row("stl_rst",  0,0,0,0,1,0, 1,0,0,0,NOPI);
        row("stl_e0",   1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("stl_e1",   1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("stl_e2",   1,0,0,0,1,0, 1,4,1,0,memf(0));
        for (int k = 0; k < 10; k++)
            row("stl_hold", 1,1,0,0,1,0, 0,0,1,0,memf(0));
        row("stl_rel",  1,0,0,0,1,0, 1,8,1,4,memf(4));
        row("stl_req8", 1,0,0,0,1,0, 0,0,0,4,NOPI);
        // redirect while waiting on 0x8; 0xDEADBEEF dropped
        row("rd_flush", 1,0,1,32'h100,1,0, 0,0,0,0,NOPI);
        row("rd_drain", 1,0,0,0,1,1, 1,32'h100,0,0,NOPI);
        row("rd_w1",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("rd_w2",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("rd_out",   1,0,0,0,1,0, 1,32'h104,1,32'h100,memf(32'h100));
        // redirect with stall and a full slot
        row("rs_flush", 1,1,1,32'h200,1,0, 0,0,0,0,NOPI);
        row("rs_d1",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("rs_d2",    1,0,0,0,1,0, 1,32'h200,0,0,NOPI);
        row("rs_w1",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("rs_w2",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("rs_out",   1,0,0,0,1,0, 1,32'h204,1,32'h200,memf(32'h200));
        // pc wrap from 0xFFFF_FFFC
        row("wr_redir", 1,0,1,32'hFFFF_FFFC,0,0, 1,32'hFFFF_FFFC,0,0,NOPI);
        row("wr_w0",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("wr_w1",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("wr_out",   1,0,0,0,1,0, 1,0,1,32'hFFFF_FFFC,memf(32'hFFFF_FFFC));
        row("wr_w2",    1,0,0,0,1,0, 0,0,0,32'hFFFF_FFFC,NOPI);
        row("wr_w3",    1,0,0,0,1,0, 0,0,0,32'hFFFF_FFFC,NOPI);
        row("wr_out0",  1,0,0,0,1,0, 1,4,1,0,memf(0));
        // reset while a response is pending
        row("mr_w0",    1,1,0,0,1,0, 0,0,1,0,memf(0));
        row("mr_w1",    1,1,0,0,1,0, 0,0,1,0,memf(0));
        row("mr_rst",   0,1,0,0,1,0, 1,0,0,0,NOPI);
        row("mr_req",   1,0,0,0,0,0, 1,0,0,0,NOPI);
        row("mr_w2",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("mr_w3",    1,0,0,0,1,0, 0,0,0,0,NOPI);
        row("mr_out",   1,0,0,0,1,0, 1,4,1,0,memf(0));

        foreach (v[i]) begin
            nrst = v[i].n; stall = v[i].s; redirect = v[i].r;
            redirect_pc = v[i].rp; ready = v[i].rdy; bad = v[i].b;
            @(posedge clk);
            #1;
            chk({v[i].tag, "/req_valid"}, {31'b0, bus.imem_req_valid},
                {31'b0, v[i].rv});
            if (v[i].rv)
                chk({v[i].tag, "/req_addr"}, bus.imem_req_addr, v[i].a);
            chk({v[i].tag, "/inst_valid"}, {31'b0, inst_valid},
                {31'b0, v[i].iv});
            chk({v[i].tag, "/pc_out"}, pc_out, v[i].p);
            chk({v[i].tag, "/inst_out"}, inst_out, v[i].ins);
        end

        // random phase: decode must see the program-order stream
        nrst = 1'b0; stall = 1'b0; redirect = 1'b0; bad = 1'b0;
        ready = 1'b1; rand_lat = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        exp_pc = 32'h0;
        gap = 0;
        consumes = 0;
        for (int c = 0; c < 3000; c++) begin
            stall    = ($urandom_range(99, 0) < 30);
            redirect = ($urandom_range(99, 0) < 3);
            ready    = ($urandom_range(99, 0) < 70);
            r = $urandom;
            redirect_pc = r & 32'hFFFF_FFFC;
            if ($urandom_range(3, 0) == 0)
                redirect_pc = 32'hFFFF_FFF0 | (r & 32'h0000_000C);
            if (!inst_valid)
                chk("rand_empty_nop", inst_out, NOPI);
            if (redirect) begin
                exp_pc = redirect_pc;
            end else if (inst_valid && !stall) begin
                chk("rand_pc", pc_out, exp_pc);
                chk("rand_inst", inst_out, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumes++;
            end
            gap = inst_valid ? 0 : gap + 1;
            if (gap > 100) begin
                chk("rand_progress_gap", gap, 100);
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rand_consumes", {31'b0, consumes >= 100}, 32'd1);

        stall = 1'b0; redirect = 1'b0; ready = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller that feeds the fetch-to-decode pipeline register. It owns the PC and issues one instruction-memory request at a time over a valid/ready request channel. It presents {inst, pc, valid} to the decode side and honours the hazard unit's stall. It squashes wrong-path fetches on branch/jump redirect (flush).

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
NOP_INST, 32'h0000_0013, encoding driven on inst_out when the slot is empty or squashed (addi x0,x0,0).

Ports:
clk  in  1  clock, all state updates on posedge
nrst  in  1  synchronous, active-low reset
stall  in  1  decode side not accepting this cycle
redirect  in  1  flush; wrong-path squash, new PC follows
redirect_pc  in  32  target PC, valid when redirect=1
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address
imem_rsp_valid  in  1  response data valid, exactly one per accepted request, latency >=1 cycle
imem_rsp_data  in  32  fetched instruction
inst_out  out  32  instruction to decode
pc_out  out  32  PC of inst_out
inst_valid  out  1  output slot holds a real instruction

Behaviour:
- Reset (nrst=0 at posedge) overrides everything:
  - pc<=RESET_PC, state<=REQ, skid empty.
  - inst_out<=NOP_INST, pc_out<=0, inst_valid<=0.
  - A reset mid-transaction abandons the outstanding request. The memory side is reset by the same nrst.
- All outputs are registered except imem_req_valid/imem_req_addr, which decode from state/pc.
- Output slot consumption: a consume occurs in any cycle with inst_valid=1 and stall=0. After a consume with nothing to load, the slot empties: inst_valid<=0, inst_out<=NOP_INST, pc_out unchanged.
- FSM states: REQ, WAIT, HOLD, DRAIN.
  - REQ: imem_req_valid=1, imem_req_addr=pc. On req_valid&req_ready: req_pc<=pc, pc<=pc+4 (mod 2^32 wrap), go WAIT. Without a handshake, valid and addr stay stable.
  - WAIT: on imem_rsp_valid:
    - If the slot is empty or being consumed this cycle, load the slot: inst_out<=rsp_data, pc_out<=req_pc, inst_valid<=1. Go REQ.
    - Otherwise write the skid buffer {rsp_data, req_pc} and go HOLD.
  - HOLD: no request issued. On consume, move skid to slot (same cycle load, inst_valid stays 1), go REQ.
  - DRAIN: wait for the response to the squashed request and discard it, then go REQ.
- Best-case throughput: one instruction per 2+L cycles (L = memory latency). Request-to-slot latency: response cycle +1.
- Redirect (highest priority after reset, wins over stall and rsp_valid):
  - pc<=redirect_pc, slot emptied (inst_valid<=0, inst_out<=NOP_INST, pc_out<=0), skid cleared.
  - Next state is DRAIN if a request is outstanding after this edge. This covers WAIT without rsp_valid, and REQ with a handshake this cycle.
  - Otherwise next state is REQ. This covers REQ without a handshake, HOLD, WAIT with rsp_valid this cycle (response dropped), and DRAIN with rsp_valid this cycle.
  - Redirect in DRAIN without rsp_valid: update pc, stay DRAIN.
  - Redirect in REQ without handshake: the address changes next cycle. The memory must tolerate an address change on an un-accepted request.
- stall=1 with the slot full: slot holds; at most one further instruction is buffered (skid); no request beyond that.
- rsp_valid outside WAIT/DRAIN is a protocol error: ignored, with a simulation-only assertion.
- Invariants: at most one outstanding request; inst_valid=0 implies inst_out=NOP_INST.

Decomposition:
- Shared package if_pkg: NOP_INST constant, fetch_state_e enum {REQ, WAIT, HOLD, DRAIN}, fetch_pkt_t struct {inst[31:0], pc[31:0]}.
- One natural sub-module: if_skid_buf, a 1-entry fetch_pkt_t buffer with load/unload/clear and a full flag, also used for the output slot.

Test Plan:
- Reset then ready=1, latency 1, stall=0 -> requests at 0x0, 0x4, 0x8. inst_out/pc_out show rsp_data with pc 0x0, 0x4, 0x8, one every 3 cycles. inst_valid pulses.
- Hold stall=1 for 10 cycles after first valid (pc_out=0x0) -> slot holds 0x0, skid holds 0x4, no third request. On stall release: 0x4 the next cycle, then request 0x8 issues.
- Redirect to 0x100 while WAIT for 0x8 -> slot cleared to NOP, next response (data 0xDEADBEEF) discarded. Next request addr=0x100, and pc_out=0x100 appears on the following valid.
- Redirect and stall asserted together with slot full -> inst_valid=0, inst_out=32'h13 next cycle. Fetch resumes at redirect_pc.
- redirect_pc=0xFFFF_FFFC -> request 0xFFFF_FFFC, then 0x0000_0000 (wrap).
- nrst=0 while WAIT with rsp pending -> all outputs at reset values. First request after reset at RESET_PC, and the stale response is not presented.
